// File: rtl/chess_clock_pkg.sv
// Shared types and constants for the chess clock player timer.
package chess_clock_pkg;

    localparam int unsigned DIGIT_W = 4;

    localparam logic [7:0] MAX_MIN = 8'h99;
    localparam logic [7:0] MAX_SEC = 8'h59;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_EXPIRED = 2'd2
    } state_e;

    // Force each digit into 0-9, then cap the tens digit (59 for seconds).
    function automatic logic [7:0] clamp_bcd(input logic [7:0] v, input logic [3:0] tens_max);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = (v[7:4] > 4'd9) ? 4'd9 : v[7:4];
        ones = (v[3:0] > 4'd9) ? 4'd9 : v[3:0];
        if (tens > tens_max) begin
            return {tens_max, 4'd9};
        end
        return {tens, ones};
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: add 0..LIMIT+1 with carry, or decrement with borrow, wrapping at LIMIT.
module bcd_digit
    import chess_clock_pkg::*;
#(
    parameter logic [DIGIT_W-1:0] LIMIT = 4'd9
) (
    input  logic [DIGIT_W-1:0] val_i,
    input  logic [DIGIT_W-1:0] add_i,
    input  logic               sub_i,
    output logic [DIGIT_W-1:0] val_o,
    output logic               carry_o,
    output logic               borrow_o
);

    logic [DIGIT_W:0] sum;

    assign sum = {1'b0, val_i} + {1'b0, add_i};

    always_comb begin
        val_o    = val_i;
        carry_o  = 1'b0;
        borrow_o = 1'b0;
        if (sub_i) begin
            if (val_i == '0) begin
                val_o    = LIMIT;
                borrow_o = 1'b1;
            end else begin
                val_o = val_i - DIGIT_W'(1);
            end
        end else if (sum > {1'b0, LIMIT}) begin
            val_o   = DIGIT_W'(sum - ({1'b0, LIMIT} + (DIGIT_W + 1)'(1)));
            carry_o = 1'b1;
        end else begin
            val_o = sum[DIGIT_W-1:0];
        end
    end

endmodule

// File: rtl/player_timer.sv
// One player's MM:SS countdown with preset load, per-move bonus and expiry/low-time flags.
module player_timer
    import chess_clock_pkg::*;
#(
    parameter logic [7:0] LOW_SEC = 8'h10
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic       CE,
    input  logic       EN,
    input  logic       LOAD,
    input  logic [7:0] PRESET_MIN,
    input  logic [7:0] PRESET_SEC,
    input  logic [3:0] INC_SEC,
    output logic [7:0] MIN,
    output logic [7:0] SEC,
    output logic       TIMEOUT,
    output logic       LOW_TIME
);

    state_e     state_q;
    logic [7:0] min_q, sec_q;
    logic [7:0] min_d, sec_d;
    logic       timeout_q;
    logic       en_q;

    logic       do_dec, do_bonus;
    logic [3:0] bonus_amt;
    logic [7:0] load_min, load_sec;

    logic [3:0] s0_d, s1_d, m0_d, m1_d;
    logic       c0, c1, c2, c3;
    logic       b0, b1, b2, b3;

    assign bonus_amt = (INC_SEC > 4'd9) ? 4'd9 : INC_SEC;
    assign do_dec    = (state_q == ST_ARMED) && CE && EN;
    assign do_bonus  = (state_q == ST_ARMED) && en_q && !EN;

    assign load_min  = clamp_bcd(PRESET_MIN, MAX_MIN[7:4]);
    assign load_sec  = clamp_bcd(PRESET_SEC, MAX_SEC[7:4]);

    // Decrement and bonus are mutually exclusive (EN high vs EN low), so one chain serves both.
    bcd_digit #(.LIMIT(4'd9)) u_sec_ones (
        .val_i(sec_q[3:0]), .add_i(do_bonus ? bonus_amt : 4'd0), .sub_i(do_dec),
        .val_o(s0_d), .carry_o(c0), .borrow_o(b0)
    );
    bcd_digit #(.LIMIT(4'd5)) u_sec_tens (
        .val_i(sec_q[7:4]), .add_i({3'b000, c0}), .sub_i(b0),
        .val_o(s1_d), .carry_o(c1), .borrow_o(b1)
    );
    bcd_digit #(.LIMIT(4'd9)) u_min_ones (
        .val_i(min_q[3:0]), .add_i({3'b000, c1}), .sub_i(b1),
        .val_o(m0_d), .carry_o(c2), .borrow_o(b2)
    );
    bcd_digit #(.LIMIT(4'd9)) u_min_tens (
        .val_i(min_q[7:4]), .add_i({3'b000, c2}), .sub_i(b2),
        .val_o(m1_d), .carry_o(c3), .borrow_o(b3)
    );

    // Saturate at 99:59 on bonus overflow; an underflow cannot occur in ARMED but pins to 00:00.
    always_comb begin
        min_d = {m1_d, m0_d};
        sec_d = {s1_d, s0_d};
        if (c3) begin
            min_d = MAX_MIN;
            sec_d = MAX_SEC;
        end else if (b3) begin
            min_d = 8'h00;
            sec_d = 8'h00;
        end
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_q   <= ST_IDLE;
            min_q     <= 8'h00;
            sec_q     <= 8'h00;
            timeout_q <= 1'b0;
            en_q      <= 1'b0;
        end else begin
            en_q <= EN;
            if (LOAD) begin
                min_q <= load_min;
                sec_q <= load_sec;
                if ((load_min == 8'h00) && (load_sec == 8'h00)) begin
                    state_q   <= ST_EXPIRED;
                    timeout_q <= 1'b1;
                end else begin
                    state_q   <= ST_ARMED;
                    timeout_q <= 1'b0;
                end
            end else if (state_q == ST_ARMED) begin
                if (do_dec || do_bonus) begin
                    min_q <= min_d;
                    sec_q <= sec_d;
                end
                if (do_dec && (min_d == 8'h00) && (sec_d == 8'h00)) begin
                    state_q   <= ST_EXPIRED;
                    timeout_q <= 1'b1;
                end
            end
        end
    end

    assign MIN      = min_q;
    assign SEC      = sec_q;
    assign TIMEOUT  = timeout_q;
    assign LOW_TIME = (state_q == ST_ARMED) && (min_q == 8'h00) && (sec_q < LOW_SEC);

endmodule

// File: tb/tb_player_timer.sv
// Self-checking bench for player_timer: directed scenarios plus random traffic against a seconds-based model.
module tb_player_timer;

    logic       CLK;
    logic       CLR;
    logic       CE;
    logic       EN;
    logic       LOAD;
    logic [7:0] PRESET_MIN;
    logic [7:0] PRESET_SEC;
    logic [3:0] INC_SEC;
    logic [7:0] MIN;
    logic [7:0] SEC;
    logic       TIMEOUT;
    logic       LOW_TIME;

    int n_vec;
    int n_err;

    // Model: remaining time in whole seconds; 0 idle, 1 armed, 2 expired.
    int m_state;
    int m_tot;
    bit m_to;
    bit m_end;

    localparam int LOW_SEC_DEC = 10;
    localparam int MAX_TOT     = 99 * 60 + 59;

    player_timer #(.LOW_SEC(8'h10)) dut (
        .CLK(CLK), .CLR(CLR), .CE(CE), .EN(EN), .LOAD(LOAD),
        .PRESET_MIN(PRESET_MIN), .PRESET_SEC(PRESET_SEC), .INC_SEC(INC_SEC),
        .MIN(MIN), .SEC(SEC), .TIMEOUT(TIMEOUT), .LOW_TIME(LOW_TIME)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    function automatic int digit_val(input logic [3:0] d);
        return (d > 4'd9) ? 9 : int'(d);
    endfunction

    function automatic int preset_tot(input logic [7:0] pm, input logic [7:0] ps);
        int mm, ss;
        mm = digit_val(pm[7:4]) * 10 + digit_val(pm[3:0]);
        ss = digit_val(ps[7:4]) * 10 + digit_val(ps[3:0]);
        if (ss > 59) ss = 59;
        return mm * 60 + ss;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".MIN"}, 32'(MIN), 32'(to_bcd(m_tot / 60)));
        chk({tag, ".SEC"}, 32'(SEC), 32'(to_bcd(m_tot % 60)));
        chk({tag, ".TIMEOUT"}, 32'(TIMEOUT), 32'(m_to));
        chk({tag, ".LOW_TIME"}, 32'(LOW_TIME),
            32'((m_state == 1) && (m_tot < 60) && (m_tot < LOW_SEC_DEC)));
    endtask

    task automatic model_edge(input bit ce, input bit en, input bit ld,
                              input logic [7:0] pm, input logic [7:0] ps, input logic [3:0] inc);
        int amt;
        amt = (inc > 4'd9) ? 9 : int'(inc);
        if (ld) begin
            m_tot   = preset_tot(pm, ps);
            m_state = (m_tot == 0) ? 2 : 1;
            m_to    = (m_tot == 0);
        end else if (m_state == 1) begin
            if (ce && en) begin
                m_tot = m_tot - 1;
                if (m_tot == 0) begin
                    m_state = 2;
                    m_to    = 1'b1;
                end
            end else if (m_end && !en) begin
                m_tot = (m_tot + amt > MAX_TOT) ? MAX_TOT : m_tot + amt;
            end
        end
        m_end = en;
    endtask

    task automatic step(input string tag, input bit ce, input bit en, input bit ld,
                        input logic [7:0] pm, input logic [7:0] ps, input logic [3:0] inc);
        CE = ce; EN = en; LOAD = ld; PRESET_MIN = pm; PRESET_SEC = ps; INC_SEC = inc;
        @(posedge CLK);
        model_edge(ce, en, ld, pm, ps, inc);
        #1;
        check_all(tag);
    endtask

    // Asynchronous clear between clock edges; outputs must drop before any edge.
    task automatic pulse_clr(input string tag);
        #2 CLR = 1'b1;
        #1;
        m_state = 0; m_tot = 0; m_to = 1'b0; m_end = 1'b0;
        check_all(tag);
        #1 CLR = 1'b0;
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        m_state = 0; m_tot = 0; m_to = 1'b0; m_end = 1'b0;
        CLR = 1'b1; CE = 1'b0; EN = 1'b0; LOAD = 1'b0;
        PRESET_MIN = 8'h00; PRESET_SEC = 8'h00; INC_SEC = 4'd0;
        #12;
        check_all("reset");
        CLR = 1'b0;
        @(negedge CLK);

        step("idle_ce", 1, 1, 0, 8'h00, 8'h00, 4'd0);

        // 05:00 countdown
        step("ld0500", 0, 1, 1, 8'h05, 8'h00, 4'd0);
        step("dec1", 1, 1, 0, 8'h00, 8'h00, 4'd0);
        for (int i = 0; i < 59; i++) step("dec59", 1, 1, 0, 8'h00, 8'h00, 4'd0);
        chk("at0400", 32'({MIN, SEC}), 32'h0400);

        // Expiry and reload
        step("ld0002", 0, 1, 1, 8'h00, 8'h02, 4'd0);
        step("exp_a", 1, 1, 0, 8'h00, 8'h00, 4'd0);
        step("exp_b", 1, 1, 0, 8'h00, 8'h00, 4'd0);
        chk("expired_to", 32'(TIMEOUT), 32'd1);
        for (int i = 0; i < 3; i++) step("exp_hold", 1, i[0], 0, 8'h00, 8'h00, 4'd5);
        step("ld0100", 0, 0, 1, 8'h01, 8'h00, 4'd0);
        step("armed_dec", 1, 1, 0, 8'h00, 8'h00, 4'd0);

        // Bonus with carry and saturation
        step("ld0055", 0, 1, 1, 8'h00, 8'h55, 4'd7);
        step("bonus7", 0, 0, 0, 8'h00, 8'h00, 4'd7);
        chk("at0102", 32'({MIN, SEC}), 32'h0102);
        step("ld9958", 0, 0, 1, 8'h99, 8'h58, 4'd5);
        step("en_up", 0, 1, 0, 8'h00, 8'h00, 4'd5);
        step("bonus_sat", 0, 0, 0, 8'h00, 8'h00, 4'd5);
        chk("at9959", 32'({MIN, SEC}), 32'h9959);
        step("en_up2", 0, 1, 0, 8'h00, 8'h00, 4'd0);
        step("ld_on_fall", 0, 0, 1, 8'h00, 8'h30, 4'd9);

        // Low-time threshold
        step("ld0012", 0, 1, 1, 8'h00, 8'h12, 4'd0);
        for (int i = 0; i < 3; i++) step("low", 1, 1, 0, 8'h00, 8'h00, 4'd0);
        chk("low_at_0009", 32'(LOW_TIME), 32'd1);

        // Clamping and async clear
        step("ld_clamp", 0, 1, 1, 8'h3C, 8'h7A, 4'd0);
        step("clamp_dec", 1, 1, 0, 8'h00, 8'h00, 4'd0);
        pulse_clr("clr_mid");
        for (int i = 0; i < 3; i++) step("post_clr", 1, 1, 0, 8'h00, 8'h00, 4'd3);
        step("post_clr_fall", 0, 0, 0, 8'h00, 8'h00, 4'd3);

        // Random traffic
        begin
            bit en_r;
            en_r = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                int r;
                bit ld_r;
                logic [7:0] pm_r;
                r = int'($urandom_range(0, 199));
                if (r == 199) begin
                    pulse_clr("rnd_clr");
                end else begin
                    if ($urandom_range(0, 7) == 0) en_r = ~en_r;
                    ld_r = (r < 4);
                    pm_r = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
                    step("rnd", $urandom_range(0, 1) == 1, en_r, ld_r, pm_r,
                         8'($urandom), 4'($urandom));
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
